// File: rtl/tetris_map_writer.sv
// Tetris block-map writer: owns the 40x30 map bus and applies game-logic
// commands (cell/row writes, board clear, line collapse) over valid/ready.
module tetris_map_writer #(
  parameter int unsigned COLS = 40,
  parameter int unsigned ROWS = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [4:0]           cmd_row,
  input  logic [5:0]           cmd_col,
  output logic                 done,
  output logic                 err,
  output logic [COLS*ROWS-1:0] map,
  input  logic [4:0]           rd_row,
  input  logic [5:0]           rd_col,
  output logic                 rd_bit,
  output logic [ROWS-1:0]      full_mask
);

  localparam int unsigned MAP_W = COLS * ROWS;
  localparam int unsigned IDX_W = 11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_SET       = 3'd1;
  localparam logic [2:0] OP_CLEAR     = 3'd2;
  localparam logic [2:0] OP_FILL_ROW  = 3'd3;
  localparam logic [2:0] OP_CLEAR_ROW = 3'd4;
  localparam logic [2:0] OP_CLEAR_ALL = 3'd5;
  localparam logic [2:0] OP_COLLAPSE  = 3'd6;
  localparam logic [2:0] OP_RSVD      = 3'd7;

  logic [1:0]       r_state;
  logic [4:0]       r_cnt;
  logic [MAP_W-1:0] r_map;
  logic             r_done;
  logic             r_err;
  logic             r_rd_bit;
  logic [ROWS-1:0]  r_full;

  logic [1:0]       w_state_nxt;
  logic [4:0]       w_cnt_nxt;
  logic [MAP_W-1:0] w_map_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_accept;
  logic             w_row_bad;
  logic             w_col_bad;
  logic             w_reject;
  logic [IDX_W-1:0] w_cell_idx;
  logic [IDX_W-1:0] w_row_base;
  logic [IDX_W-1:0] w_cnt_base;
  logic [IDX_W-1:0] w_src_base;
  logic             w_rd_ok;
  logic [IDX_W-1:0] w_rd_idx;
  logic [ROWS-1:0]  w_full;

  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;

  assign w_row_bad  = cmd_row >= 5'(ROWS);
  assign w_col_bad  = cmd_col >= 6'(COLS);
  assign w_row_base = IDX_W'(cmd_row) * IDX_W'(COLS);
  assign w_cell_idx = w_row_base + IDX_W'(cmd_col);
  assign w_cnt_base = IDX_W'(r_cnt) * IDX_W'(COLS);
  assign w_src_base = w_cnt_base - IDX_W'(COLS);

  assign w_rd_ok  = (rd_row < 5'(ROWS)) && (rd_col < 6'(COLS));
  assign w_rd_idx = IDX_W'(rd_row) * IDX_W'(COLS) + IDX_W'(rd_col);

  // Per-row all-ones detect feeding the registered full mask
  for (genvar k = 0; k < int'(ROWS); k++) begin : g_full
    assign w_full[k] = &r_map[k*COLS +: COLS];
  end

  // Command legality: bad row/column for ops that use them, reserved op
  always_comb begin
    w_reject = 1'b0;
    case (cmd_op)
      OP_SET, OP_CLEAR:                     w_reject = w_row_bad || w_col_bad;
      OP_FILL_ROW, OP_CLEAR_ROW, OP_COLLAPSE: w_reject = w_row_bad;
      OP_RSVD:                              w_reject = 1'b1;
      default:                              w_reject = 1'b0;
    endcase
  end

  // Next-state, next-map and completion pulses
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_map_nxt   = r_map;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_reject) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end else begin
            case (cmd_op)
              OP_SET: begin
                w_map_nxt[w_cell_idx] = 1'b1;
                w_done_nxt = 1'b1;
              end
              OP_CLEAR: begin
                w_map_nxt[w_cell_idx] = 1'b0;
                w_done_nxt = 1'b1;
              end
              OP_FILL_ROW: begin
                w_map_nxt[w_row_base +: COLS] = '1;
                w_done_nxt = 1'b1;
              end
              OP_CLEAR_ROW: begin
                w_map_nxt[w_row_base +: COLS] = '0;
                w_done_nxt = 1'b1;
              end
              OP_CLEAR_ALL: begin
                w_state_nxt = S_SWEEP;
                w_cnt_nxt   = '0;
              end
              OP_COLLAPSE: begin
                w_state_nxt = S_SHIFT;
                w_cnt_nxt   = cmd_row;
              end
              default: w_done_nxt = 1'b1;
            endcase
          end
        end
      end
      S_SWEEP: begin
        w_map_nxt[w_cnt_base +: COLS] = '0;
        if (r_cnt == 5'(ROWS - 1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      S_SHIFT: begin
        if (r_cnt != 5'd0) begin
          w_map_nxt[w_cnt_base +: COLS] = r_map[w_src_base +: COLS];
          w_cnt_nxt = r_cnt - 5'd1;
        end else begin
          w_map_nxt[0 +: COLS] = '0;
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, map and registered outputs; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_map    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rd_bit <= 1'b0;
      r_full   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_map    <= w_map_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_rd_bit <= w_rd_ok && r_map[w_rd_idx];
      r_full   <= w_full;
    end
  end

  assign map       = r_map;
  assign done      = r_done;
  assign err       = r_err;
  assign rd_bit    = r_rd_bit;
  assign full_mask = r_full;

endmodule
